bcp_implication_queue: RTL and testbench
========================================

Name: bcp_implication_queue

Overview:
- Consumer end of the clause-evaluation path in hardware_bcp.
- Accepts per-clause results (unit / conflict / nothing) from the clause evaluators and keeps a deduplicated FIFO of implied literals.
- Serially hands those literals to the assignment engine over valid/ready.
- Detects contradictory implications and raises a sticky conflict for the controller.

Parameters:
- VAR_W, 6, variable index width (up to 64 variables).
- DEPTH, 8, FIFO entries; power of two, >=2.
- CNT_W, 8, width of saturating drop counter.

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush: empties FIFO, bitmap, conflict, drop_cnt.
- res_valid  in  1  clause result valid.
- res_ready  out  1  queue can accept a result.
- res_unit  in  1  clause is unit; res_var/res_sign give the implied literal.
- res_conflict  in  1  clause is falsified.
- res_var  in  VAR_W  implied / conflicting variable.
- res_sign  in  1  implied value (1 = true).
- imp_valid  out  1  head literal available.
- imp_ready  in  1  assignment engine takes head.
- imp_var  out  VAR_W  head variable.
- imp_sign  out  1  head value.
- conflict  out  1  sticky conflict flag.
- conflict_var  out  VAR_W  variable that caused the first conflict.
- pending_cnt  out  log2(DEPTH)+1  FIFO occupancy.
- drop_cnt  out  CNT_W  duplicates dropped, saturating.

Behaviour:
- Reset: all outputs 0, FIFO empty, pend_valid bitmap all 0. Asynchronous assert, synchronous deassert is the integrator's job.
- res_ready = !conflict && (pending_cnt != DEPTH). No same-cycle pop bypass when full.
- Accept = res_valid && res_ready. Priority on accept:
  1. res_conflict=1 → conflict<=1, conflict_var<=res_var. res_unit is ignored.
  2. res_unit=1, pend_valid[var]=0 → push {var,sign}; set pend_valid[var], pend_sign[var].
  3. res_unit=1, pend_valid[var]=1, same sign → drop; drop_cnt+1 (saturates at all-ones).
  4. res_unit=1, pend_valid[var]=1, opposite sign → conflict<=1, conflict_var<=res_var; no push.
  5. res_unit=0 and res_conflict=0 → consumed, no effect.
- Bitmap lookup uses the registered (pre-pop) state. A same-sign result matching the head popped in the same cycle is a duplicate and is dropped. An opposite-sign match is a conflict.
- imp_valid = !conflict && (pending_cnt != 0). imp_var/imp_sign are driven from the registered FIFO head.
- Pop = imp_valid && imp_ready: advance read pointer, clear pend_valid[head var].
- Same-cycle push and pop on a different var: both happen, count unchanged.
- Latency: an accepted literal appears on imp_* in the next cycle, at the earliest.
- Pointers wrap modulo DEPTH. pending_cnt is exact, 0..DEPTH.
- conflict is sticky:
  - while set, res_ready=0 and imp_valid=0;
  - FIFO contents are frozen;
  - conflict_var holds the first cause.
- clear has priority over every event in its cycle: next cycle, everything is in the reset state.
- Reset mid-operation discards everything immediately, including any in-flight handshake.

Decomposition:
- Package bcp_pkg holds:
  - localparam VAR_W default;
  - typedef lit_t packed {sign, var[VAR_W-1:0]};
  - result-kind enum {RES_NONE, RES_UNIT, RES_CONFLICT}.
- Sub-module bcp_lit_fifo: a generic DEPTH×lit_t synchronous FIFO with push/pop/clear, count, and a head output.
- Bitmap, dedup, conflict and counter logic live in the top.

Test Plan:
- Reset, then push unit (var=5, sign=1) → imp_valid=1 the next cycle, imp_var=5, imp_sign=1, pending_cnt=1. Pop with imp_ready=1 → pending_cnt=0, pend_valid[5]=0.
- Push var=3 sign=0 twice while imp_ready=0 → pending_cnt=1, drop_cnt=1. After the pop, push var=3 sign=0 again → accepted, pending_cnt=1.
- Push var=7 sign=1, then var=7 sign=0 → conflict=1, conflict_var=7, res_ready=0, imp_valid=0. Assert clear → all outputs 0, res_ready=1.
- Push 8 distinct vars with imp_ready=0 → res_ready=0 at pending_cnt=8. Then drain with imp_ready=1 → literals come out in push order, and continuing pushes wrap pointers correctly.
- res_conflict=1 with var=12 while the FIFO holds 3 entries → conflict_var=12, pending_cnt stays 3, no pops occur.
- Assert rst_n low mid-stream (FIFO holding 4, drop_cnt=2) → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bcp_implication_queue_pkg.sv
// rtl/bcp_implication_queue_pkg.sv - shared types for the BCP implication queue
package bcp_pkg;

   localparam int VAR_W = 6;

   // Implied literal: value bit above the variable index
   typedef struct packed {
      logic             sign;
      logic [VAR_W-1:0] var_idx;
   } lit_t;

   typedef enum logic [1:0] {
      RES_NONE,
      RES_UNIT,
      RES_CONFLICT
   } res_kind_e;

   // A falsified clause outranks a unit flag on the same result
   function automatic res_kind_e classify(input logic unit, input logic confl);
      if (confl)
         return RES_CONFLICT;
      else if (unit)
         return RES_UNIT;
      else
         return RES_NONE;
   endfunction

endpackage

// File: rtl/bcp_implication_queue_if.sv
// rtl/bcp_implication_queue_if.sv - clause-result and implication handshake bundle
interface bcp_implication_queue_if #(
   parameter int VAR_W = bcp_pkg::VAR_W
);
   logic             res_valid;
   logic             res_ready;
   logic             res_unit;
   logic             res_conflict;
   logic [VAR_W-1:0] res_var;
   logic             res_sign;
   logic             imp_valid;
   logic             imp_ready;
   logic [VAR_W-1:0] imp_var;
   logic             imp_sign;

   // Evaluators / assignment engine side
   modport master (
      output res_valid, res_unit, res_conflict, res_var, res_sign, imp_ready,
      input  res_ready, imp_valid, imp_var, imp_sign
   );

   // Queue side
   modport slave (
      input  res_valid, res_unit, res_conflict, res_var, res_sign, imp_ready,
      output res_ready, imp_valid, imp_var, imp_sign
   );
endinterface

// File: rtl/bcp_implication_queue_fifo.sv
// rtl/bcp_implication_queue_fifo.sv - generic literal FIFO with flush, count and head
module bcp_lit_fifo #(
   parameter  int W     = 7,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic         clock,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [AW:0]  count
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;

   // Pointer/count update; caller never pushes when full nor pops when empty
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (clear) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) wr_d = wr_q + 1'b1;
         if (pop)  rd_d = rd_q + 1'b1;
         cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // Pointer and count registers
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage write; contents are only observed through a non-empty head
   always_ff @(posedge clock) begin
      if (push && !clear)
         mem_q[wr_q] <= push_data;
   end

   assign head  = (cnt_q != '0) ? mem_q[rd_q] : '0;
   assign count = cnt_q;

endmodule

// File: rtl/bcp_implication_queue.sv
// rtl/bcp_implication_queue.sv - dedup implication FIFO with sticky conflict detection
module bcp_implication_queue
   import bcp_pkg::*;
#(
   parameter  int VAR_W = bcp_pkg::VAR_W,
   parameter  int DEPTH = 8,
   parameter  int CNT_W = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int NV    = 1 << VAR_W
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic                  clear,
   bcp_implication_queue_if.slave bus,
   output logic                  conflict,
   output logic [VAR_W-1:0]      conflict_var,
   output logic [AW:0]           pending_cnt,
   output logic [CNT_W-1:0]      drop_cnt
);
   logic             conflict_q, conflict_d;
   logic [VAR_W-1:0] conflict_var_q, conflict_var_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic [NV-1:0]    pend_valid_q, pend_valid_d;
   logic [NV-1:0]    pend_sign_q, pend_sign_d;

   logic [VAR_W:0]   head;
   logic             accept, pop, push, dup, set_conf;
   res_kind_e        kind;

   assign bus.res_ready = !conflict_q && (pending_cnt != (AW+1)'(DEPTH));
   assign bus.imp_valid = !conflict_q && (pending_cnt != '0);
   assign bus.imp_var   = head[VAR_W-1:0];
   assign bus.imp_sign  = head[VAR_W];

   assign accept = bus.res_valid && bus.res_ready;
   assign pop    = bus.imp_valid && bus.imp_ready;
   assign kind   = classify(bus.res_unit, bus.res_conflict);

   // Classify an accepted result against the pre-pop pending bitmap
   always_comb begin
      push     = 1'b0;
      dup      = 1'b0;
      set_conf = 1'b0;
      if (accept) begin
         case (kind)
            RES_CONFLICT: set_conf = 1'b1;
            RES_UNIT: begin
               if (!pend_valid_q[bus.res_var])
                  push = 1'b1;
               else if (pend_sign_q[bus.res_var] == bus.res_sign)
                  dup = 1'b1;
               else
                  set_conf = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Next state for bitmap, conflict capture and saturating drop counter
   always_comb begin
      pend_valid_d   = pend_valid_q;
      pend_sign_d    = pend_sign_q;
      conflict_d     = conflict_q;
      conflict_var_d = conflict_var_q;
      drop_d         = drop_q;
      if (clear) begin
         pend_valid_d   = '0;
         pend_sign_d    = '0;
         conflict_d     = 1'b0;
         conflict_var_d = '0;
         drop_d         = '0;
      end else begin
         // Head var differs from any pushed var, since a push needs a clear bit
         if (pop)
            pend_valid_d[head[VAR_W-1:0]] = 1'b0;
         if (push) begin
            pend_valid_d[bus.res_var] = 1'b1;
            pend_sign_d[bus.res_var]  = bus.res_sign;
         end
         if (set_conf) begin
            conflict_d     = 1'b1;
            conflict_var_d = bus.res_var;
         end
         if (dup && (drop_q != '1))
            drop_d = drop_q + 1'b1;
      end
   end

   // State registers
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid_q   <= '0;
         pend_sign_q    <= '0;
         conflict_q     <= 1'b0;
         conflict_var_q <= '0;
         drop_q         <= '0;
      end else begin
         pend_valid_q   <= pend_valid_d;
         pend_sign_q    <= pend_sign_d;
         conflict_q     <= conflict_d;
         conflict_var_q <= conflict_var_d;
         drop_q         <= drop_d;
      end
   end

   bcp_lit_fifo #(
      .W     (VAR_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .rst_n     (rst_n),
      .clear     (clear),
      .push      (push),
      .push_data ({bus.res_sign, bus.res_var}),
      .pop       (pop),
      .head      (head),
      .count     (pending_cnt)
   );

   assign conflict     = conflict_q;
   assign conflict_var = conflict_var_q;
   assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_bcp_implication_queue.sv
// tb/tb_bcp_implication_queue.sv - randomized model-checked bench for bcp_implication_queue
module tb_bcp_implication_queue;
   localparam int VW    = 6;
   localparam int DEPTH = 8;
   localparam int CW    = 8;

   logic clock = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;

   always #5 clock = ~clock;

   bcp_implication_queue_if #(.VAR_W(VW)) bus();

   logic          conflict;
   logic [VW-1:0] conflict_var;
   logic [3:0]    pending_cnt;
   logic [CW-1:0] drop_cnt;

   bcp_implication_queue #(
      .VAR_W (VW),
      .DEPTH (DEPTH),
      .CNT_W (CW)
   ) dut (
      .clock        (clock),
      .rst_n        (rst_n),
      .clear        (clear),
      .bus          (bus),
      .conflict     (conflict),
      .conflict_var (conflict_var),
      .pending_cnt  (pending_cnt),
      .drop_cnt     (drop_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: ordered list of pending literals {sign,var}, conflict state, drop count
   logic [VW:0] mq[$];
   bit          m_conf;
   int          m_cvar;
   int          m_drop;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit v, input bit u, input bit c, input int vr, input bit s, input bit ir);
      bus.res_valid    = v;
      bus.res_unit     = u;
      bus.res_conflict = c;
      bus.res_var      = VW'(vr);
      bus.res_sign     = s;
      bus.imp_ready    = ir;
   endtask

   task automatic model_reset();
      mq.delete();
      m_conf = 1'b0;
      m_cvar = 0;
      m_drop = 0;
   endtask

   // Compare every DUT output against the model's current state
   task automatic check_model();
      bit exp_ready, exp_iv;
      exp_ready = !m_conf && (mq.size() != DEPTH);
      exp_iv    = !m_conf && (mq.size() != 0);
      chk("res_ready", 32'(bus.res_ready), 32'(exp_ready));
      chk("imp_valid", 32'(bus.imp_valid), 32'(exp_iv));
      chk("conflict", 32'(conflict), 32'(m_conf));
      chk("conflict_var", 32'(conflict_var), 32'(m_cvar));
      chk("pending_cnt", 32'(pending_cnt), 32'(mq.size()));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (exp_iv) begin
         chk("imp_var", 32'(bus.imp_var), 32'(mq[0][VW-1:0]));
         chk("imp_sign", 32'(bus.imp_sign), 32'(mq[0][VW]));
      end
   endtask

   // Advance the model by one clock using the inputs held across the edge
   task automatic model_step();
      bit ready, iv, do_pop, do_push, found, fsign;
      if (clear) begin
         model_reset();
         return;
      end
      ready   = !m_conf && (mq.size() != DEPTH);
      iv      = !m_conf && (mq.size() != 0);
      do_pop  = iv && bus.imp_ready;
      do_push = 1'b0;
      found   = 1'b0;
      fsign   = 1'b0;
      foreach (mq[i]) begin
         if (mq[i][VW-1:0] == bus.res_var) begin
            found = 1'b1;
            fsign = mq[i][VW];
         end
      end
      if (bus.res_valid && ready) begin
         if (bus.res_conflict) begin
            m_conf = 1'b1;
            m_cvar = int'(bus.res_var);
         end else if (bus.res_unit) begin
            if (!found)
               do_push = 1'b1;
            else if (fsign == bus.res_sign)
               m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            else begin
               m_conf = 1'b1;
               m_cvar = int'(bus.res_var);
            end
         end
      end
      if (do_pop)
         void'(mq.pop_front());
      if (do_push)
         mq.push_back({bus.res_sign, bus.res_var});
   endtask

   task automatic cycle();
      check_model();
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic idle(input bit ir);
      drive(0, 0, 0, 0, 0, ir);
   endtask

   task automatic do_clear();
      idle(0);
      clear = 1'b1;
      cycle();
      clear = 1'b0;
   endtask

   initial begin
      model_reset();
      idle(0);
      #12;
      chk("rst_imp_valid", 32'(bus.imp_valid), 32'd0);
      chk("rst_imp_var", 32'(bus.imp_var), 32'd0);
      chk("rst_pending", 32'(pending_cnt), 32'd0);
      chk("rst_conflict", 32'(conflict), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      @(posedge clock);
      #1;
      rst_n = 1'b1;

      // Single push then pop
      drive(1, 1, 0, 5, 1, 0);
      cycle();
      idle(0);
      chk("t1_imp_valid", 32'(bus.imp_valid), 32'd1);
      chk("t1_imp_var", 32'(bus.imp_var), 32'd5);
      chk("t1_imp_sign", 32'(bus.imp_sign), 32'd1);
      chk("t1_pending", 32'(pending_cnt), 32'd1);
      idle(1);
      cycle();
      chk("t1_pending_after_pop", 32'(pending_cnt), 32'd0);
      drive(1, 1, 0, 5, 0, 0);
      cycle();
      chk("t1_bitmap_cleared", 32'(conflict), 32'd0);
      chk("t1_repush_pending", 32'(pending_cnt), 32'd1);
      idle(1);
      cycle();

      // Duplicate drop, then re-accept after pop
      drive(1, 1, 0, 3, 0, 0);
      cycle();
      cycle();
      idle(0);
      chk("t2_pending", 32'(pending_cnt), 32'd1);
      chk("t2_drop", 32'(drop_cnt), 32'd1);
      idle(1);
      cycle();
      drive(1, 1, 0, 3, 0, 0);
      cycle();
      chk("t2_reaccept", 32'(pending_cnt), 32'd1);
      idle(1);
      cycle();

      // Opposite-sign implication, then clear
      drive(1, 1, 0, 7, 1, 0);
      cycle();
      drive(1, 1, 0, 7, 0, 0);
      cycle();
      idle(0);
      chk("t3_conflict", 32'(conflict), 32'd1);
      chk("t3_conflict_var", 32'(conflict_var), 32'd7);
      chk("t3_res_ready", 32'(bus.res_ready), 32'd0);
      chk("t3_imp_valid", 32'(bus.imp_valid), 32'd0);
      do_clear();
      chk("t3_clr_conflict", 32'(conflict), 32'd0);
      chk("t3_clr_res_ready", 32'(bus.res_ready), 32'd1);
      chk("t3_clr_pending", 32'(pending_cnt), 32'd0);
      chk("t3_clr_drop", 32'(drop_cnt), 32'd0);

      // Fill to DEPTH, then drain while continuing to push (pointer wrap)
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 1, 0, 10 + i, i[0], 0);
         cycle();
      end
      idle(0);
      chk("t4_full_cnt", 32'(pending_cnt), 32'd8);
      chk("t4_full_ready", 32'(bus.res_ready), 32'd0);
      chk("t4_head", 32'(bus.imp_var), 32'd10);
      for (int i = 0; i < 12; i++) begin
         drive(1, 1, 0, 30 + i, 1, 1);
         cycle();
      end
      idle(1);
      for (int i = 0; i < 10; i++) cycle();
      chk("t4_drained", 32'(pending_cnt), 32'd0);

      // Explicit clause conflict with 3 entries pending
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, 40 + i, 0, 0);
         cycle();
      end
      drive(1, 1, 1, 12, 1, 0);
      cycle();
      idle(1);
      cycle();
      cycle();
      chk("t5_conflict_var", 32'(conflict_var), 32'd12);
      chk("t5_pending", 32'(pending_cnt), 32'd3);
      do_clear();

      // Asynchronous reset mid-stream
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 0, 20 + i, 1, 0);
         cycle();
      end
      drive(1, 1, 0, 21, 1, 0);
      cycle();
      cycle();
      chk("t6_pre_pending", 32'(pending_cnt), 32'd4);
      chk("t6_pre_drop", 32'(drop_cnt), 32'd2);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_pending", 32'(pending_cnt), 32'd0);
      chk("t6_rst_drop", 32'(drop_cnt), 32'd0);
      chk("t6_rst_imp_valid", 32'(bus.imp_valid), 32'd0);
      chk("t6_rst_imp_var", 32'(bus.imp_var), 32'd0);
      model_reset();
      idle(0);
      @(posedge clock);
      #1;
      rst_n = 1'b1;

      // Randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         drive(($urandom % 4) != 0, ($urandom % 8) != 0, ($urandom % 60) == 0,
               int'($urandom % 12), $urandom % 2, ($urandom % 3) != 0);
         clear = (($urandom % 70) == 0);
         cycle();
      end
      clear = 1'b0;
      idle(0);
      check_model();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
